// File: rtl/fetch_queue.sv
// Instruction fetch front end: credit-limited prefetch FIFO between in-order instruction memory and decode.
// Optional same-cycle response bypass when built with FETCH_BYPASS_EN defined.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memReady,
    input  logic        memValid,
    input  logic [31:0] memData,
    output logic        instValid,
    output logic [31:0] instruction,
    output logic [31:0] instPC,
    input  logic        instReady,
    input  logic        redirect,
    input  logic [31:0] redirectPC
);

    localparam int unsigned PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW        = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP_INSN  = 32'h0000_0033;
    localparam logic [CW:0] CREDIT    = (CW + 1)'(DEPTH);

    // Handshakes: a request transfers when memReq && memReady; a response transfers
    // whenever memValid is high (no back-pressure to memory); decode takes the head
    // when instValid && instReady. Redirect overrides every transfer except memValid.

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [31:0]   r_q_data [DEPTH];
    logic [31:0]   r_q_pc   [DEPTH];

    logic [CW:0]   w_credit_used;
    logic          w_issue;
    logic          w_accept;
    logic          w_resp_keep;
    logic          w_bypass;
    logic          w_bypass_take;
    logic          w_push;
    logic          w_pop;
    logic          w_has_head;
    logic [31:0]   w_redirect_pc;
    logic [CW-1:0] w_left_in_flight;

    // Queued words plus requests still in memory may never exceed DEPTH, so a
    // response always finds a free slot.
    assign w_credit_used    = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_issue          = reset_n && !redirect && (w_credit_used < CREDIT);
    assign w_accept         = w_issue && memReady;
    assign w_resp_keep      = memValid && (r_discard == '0);
    assign w_has_head       = (r_count != '0);
    assign w_redirect_pc    = {redirectPC[31:2], 2'b00};
    assign w_left_in_flight = r_outstanding - CW'(memValid);

`ifdef FETCH_BYPASS_EN
    assign w_bypass = reset_n && !w_has_head && w_resp_keep && !redirect;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_bypass_take = w_bypass && instReady;
    assign w_push        = w_resp_keep && !w_bypass_take;
    assign w_pop         = w_has_head && instReady;

    assign memReq  = w_issue;
    assign memAddr = r_fetch_pc;

    always_comb begin
        instValid   = 1'b0;
        instruction = NOP_INSN;
        instPC      = 32'h0000_0000;
        if (w_has_head) begin
            instValid   = 1'b1;
            instruction = r_q_data[r_rd_ptr];
            instPC      = r_q_pc[r_rd_ptr];
        end else if (w_bypass) begin
            instValid   = 1'b1;
            instruction = memData;
            instPC      = r_resp_pc;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else if (redirect) begin
            // Everything still in memory after this edge belongs to the old path.
            r_fetch_pc    <= w_redirect_pc;
            r_resp_pc     <= w_redirect_pc;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_outstanding <= w_left_in_flight;
            r_discard     <= w_left_in_flight;
        end else begin
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            r_outstanding <= r_outstanding + CW'(w_accept) - CW'(memValid);
            if (memValid && (r_discard != '0)) begin
                r_discard <= r_discard - 1'b1;
            end
            if (w_resp_keep) begin
                r_resp_pc <= r_resp_pc + 32'd4;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (!redirect && w_push) begin
            r_q_data[r_wr_ptr] <= memData;
            r_q_pc[r_wr_ptr]   <= r_resp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios then randomized traffic, checked against an
// in-order memory model and the expected sequential instruction stream.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] NOP_INSN = 32'h0000_0033;
`ifdef FETCH_BYPASS_EN
    localparam int FIRST_VALID = 1;
`else
    localparam int FIRST_VALID = 2;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memReady = 1'b0;
    logic        memValid = 1'b0;
    logic [31:0] memData = 32'h0;
    logic        instValid;
    logic [31:0] instruction;
    logic [31:0] instPC;
    logic        instReady = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirectPC = 32'h0;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock(clock), .reset_n(reset_n),
        .memReq(memReq), .memAddr(memAddr), .memReady(memReady),
        .memValid(memValid), .memData(memData),
        .instValid(instValid), .instruction(instruction), .instPC(instPC),
        .instReady(instReady), .redirect(redirect), .redirectPC(redirectPC)
    );

    always #5 clock = ~clock;

    // Memory model: accepted addresses with the cycle their data may return.
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;
    int          cyc;
    int          lat = 1;
    int          mr_pct = 100;
    int          mv_pct = 100;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_issued = 0;
    int          n_popped = 0;
    logic        s_req, s_val;
    logic [31:0] s_addr, s_ipc, s_ins;
    int          base;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        memValid = 1'b0; memReady = 1'b0; memData = 32'h0;
        instReady = 1'b0; redirect = 1'b0; redirectPC = 32'h0;
        repeat (2) @(negedge clock);
        mq_addr.delete();
        mq_due.delete();
        exp_pc = RESET_PC;
        exp_fetch = RESET_PC;
        cyc = 0;
        reset_n = 1'b1;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input logic dec_rdy, input logic redir, input logic [31:0] rpc);
        instReady = dec_rdy;
        redirect = redir;
        redirectPC = rpc;
        memReady = ($urandom_range(99) < mr_pct);
        if (mq_addr.size() != 0 && mq_due[0] <= cyc && $urandom_range(99) < mv_pct) begin
            memValid = 1'b1;
            memData = mem_word(mq_addr[0]);
        end else begin
            memValid = 1'b0;
            memData = $urandom;
        end
        #1;
        s_req = memReq; s_addr = memAddr;
        s_val = instValid; s_ipc = instPC; s_ins = instruction;
        if (!s_val) chk("idle_nop", s_ins, NOP_INSN);
        if (redir) begin
            chk("req_in_redirect", 32'(s_req), 32'd0);
        end else begin
            if (s_val && dec_rdy) begin
                chk("pop_pc", s_ipc, exp_pc);
                chk("pop_data", s_ins, mem_word(exp_pc));
                exp_pc += 32'd4;
                n_popped++;
            end
            if (s_req && memReady) begin
                chk("issue_addr", s_addr, exp_fetch);
                exp_fetch += 32'd4;
                n_issued++;
            end
        end
        @(posedge clock);
        if (memValid) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (s_req && memReady) begin
            mq_addr.push_back(s_addr);
            mq_due.push_back(cyc + lat);
        end
        if (redir) begin
            exp_pc = {rpc[31:2], 2'b00};
            exp_fetch = {rpc[31:2], 2'b00};
        end
        chk("credit_bound", 32'(mq_addr.size() <= DEPTH), 32'd1);
        cyc++;
        @(negedge clock);
    endtask

    initial begin
        // Reset state while reset is held.
        #1;
        chk("rst_req", 32'(memReq), 32'd0);
        chk("rst_valid", 32'(instValid), 32'd0);
        chk("rst_insn", instruction, NOP_INSN);
        chk("rst_pc", instPC, 32'd0);

        // Streaming with 1-cycle memory and decode always ready.
        lat = 1; mr_pct = 100; mv_pct = 100;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            step(1'b1, 1'b0, 32'h0);
            chk("t1_valid", 32'(s_val), 32'(c >= FIRST_VALID));
            chk("t1_req", 32'(s_req), 32'd1);
        end

        // Decode stalled: fill to DEPTH, then drain back to back.
        do_reset();
        base = n_issued;
        for (int c = 0; c < 10; c++) step(1'b0, 1'b0, 32'h0);
        chk("t2_issued", 32'(n_issued - base), 32'(DEPTH));
        chk("t2_req_off", 32'(s_req), 32'd0);
        chk("t2_head_valid", 32'(s_val), 32'd1);
        chk("t2_head_pc", s_ipc, RESET_PC);
        for (int c = 0; c < DEPTH; c++) begin
            step(1'b1, 1'b0, 32'h0);
            chk("t2_drain_valid", 32'(s_val), 32'd1);
        end

        // 3-cycle memory, redirect with two requests in flight.
        lat = 3;
        do_reset();
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        chk("t3_in_flight", 32'(mq_addr.size()), 32'd2);
        step(1'b1, 1'b1, 32'h0040_0103);
        base = n_popped;
        step(1'b1, 1'b0, 32'h0);
        chk("t3_valid_off", 32'(s_val), 32'd0);
        chk("t3_first_req", 32'(s_req), 32'd1);
        chk("t3_first_addr", s_addr, 32'h0040_0100);
        for (int c = 0; c < 12; c++) step(1'b1, 1'b0, 32'h0);
        chk("t3_progress", 32'(n_popped - base > 0), 32'd1);

        // Redirect in the same cycle as a response and a ready decode.
        lat = 2;
        do_reset();
        for (int c = 0; c < 5; c++) step(1'b1, 1'b0, 32'h0);
        base = n_popped;
        step(1'b1, 1'b1, 32'h0040_0200);
        chk("t4_resp_in_redirect", 32'(memValid), 32'd1);
        chk("t4_valid_in_redirect", 32'(s_val), 32'd1);
        chk("t4_no_pop", 32'(n_popped - base), 32'd0);
        step(1'b1, 1'b0, 32'h0);
        chk("t4_empty_next", 32'(s_val), 32'd0);
        for (int c = 0; c < 10; c++) step(1'b1, 1'b0, 32'h0);
        chk("t4_progress", 32'(n_popped - base > 0), 32'd1);

        // Simultaneous push and pop with two queued, wrapping past the last entry.
        lat = 1;
        do_reset();
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 32'h0);
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 1'b0, 32'h0);
            chk("t5_valid", 32'(s_val), 32'd1);
            chk("t5_req", 32'(s_req), 32'd1);
        end

        // Asynchronous reset mid-stream with requests in flight.
        lat = 3;
        do_reset();
        for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 32'h0);
        chk("t6_in_flight", 32'(mq_addr.size() >= 2), 32'd1);
        #2;
        reset_n = 1'b0;
        memValid = 1'b0;
        #1;
        chk("t6_req", 32'(memReq), 32'd0);
        chk("t6_valid", 32'(instValid), 32'd0);
        chk("t6_insn", instruction, NOP_INSN);
        chk("t6_pc", instPC, 32'd0);
        lat = 1;
        @(negedge clock);
        do_reset();
        step(1'b1, 1'b0, 32'h0);
        chk("t6_restart_req", 32'(s_req), 32'd1);
        chk("t6_restart_addr", s_addr, RESET_PC);
        for (int c = 0; c < 6; c++) step(1'b1, 1'b0, 32'h0);

        // Randomized traffic: variable latency, stalls and redirects.
        mr_pct = 70; mv_pct = 80;
        do_reset();
        base = n_popped;
        for (int c = 0; c < 800; c++) begin
            if (c % 50 == 0) lat = $urandom_range(1, 4);
            if ($urandom_range(99) < 3)
                step(($urandom_range(99) < 70), 1'b1, $urandom);
            else
                step(($urandom_range(99) < 70), 1'b0, 32'h0);
        end
        chk("rand_progress", 32'(n_popped - base > 50), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
